fmul_mag_core: RTL and testbench

//  Multi-cycle IEEE-754 single-precision magnitude multiplier (sign handled outside).

---
 rtl/fmul_mag_core.sv | 171 +++++++++++++++++
 tb/tb_fmul_mag_core.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_mag_core.sv
`default_nettype none
// ============================================================================
// Module      : fmul_mag_core
// Description : Multi-cycle single-precision magnitude multiplier (finite path
//               only). Shift-add 24x24 mantissa product, normalise, range check.
//               Optional macro ROUND_NEAREST_EN selects round-to-nearest-even;
//               otherwise the result is truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module fmul_mag_core #(
    parameter int EW   = 8,
    parameter int MW   = 23,
    parameter int BIAS = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [30:0] a,
    input  logic [30:0] b,
    output logic        busy,
    output logic        done,
    output logic [30:0] out,
    output logic        ovf,
    output logic        unf
);

    localparam int SW = MW + 1;
    localparam int PW = 2 * SW;
    localparam int XW = EW + 2;
    localparam int CW = $clog2(SW + 1);
    localparam logic [CW-1:0]        c_last_step = CW'(SW);
    localparam logic signed [XW-1:0] c_exp_max   = XW'((1 << EW) - 1);
    localparam logic signed [XW-1:0] c_exp_zero  = '0;
    localparam logic signed [XW-1:0] c_exp_one   = XW'(1);
    localparam logic signed [XW-1:0] c_bias      = XW'(BIAS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [PW-1:0]          r_acc;
    logic [PW-1:0]          r_mcand;
    logic [SW-1:0]          r_mplier;
    logic [CW-1:0]          r_cnt;
    logic signed [XW-1:0]   r_exp;
    logic                   r_zero;

    logic [MW-1:0]          w_frac_t;
    logic                   w_guard;
    logic                   w_sticky;
    logic                   w_round_up;
    logic [MW:0]            w_frac_r;
    logic signed [XW-1:0]   w_exp_n;
    logic signed [XW-1:0]   w_exp_r;
    logic                   w_unused;

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_MUL;
                end
            end
            S_MUL: begin
                busy = 1'b1;
                // One extra MUL cycle after the last step aligns latency to 26.
                if (r_cnt == c_last_step) begin
                    w_state_next = S_NORM;
                end
            end
            S_NORM: begin
                busy         = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_frac_t = r_acc[PW-3 -: MW];
        w_guard  = r_acc[PW-3-MW];
        w_sticky = |r_acc[PW-4-MW:0];
        w_exp_n  = r_exp;
        if (r_acc[PW-1]) begin
            w_frac_t = r_acc[PW-2 -: MW];
            w_guard  = r_acc[PW-2-MW];
            w_sticky = |r_acc[PW-3-MW:0];
            w_exp_n  = r_exp + c_exp_one;
        end
`ifdef ROUND_NEAREST_EN
        w_round_up = w_guard & (w_sticky | w_frac_t[0]);
`else
        w_round_up = 1'b0;
`endif
        w_frac_r = {1'b0, w_frac_t} + {{MW{1'b0}}, w_round_up};
        // A carry out of the fraction means the mantissa rounded up to 2.0.
        w_exp_r  = w_frac_r[MW] ? (w_exp_n + c_exp_one) : w_exp_n;
    end

    assign w_unused = &{1'b0, w_guard, w_sticky};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_exp    <= '0;
            r_zero   <= 1'b0;
            out      <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= {{SW{1'b0}}, 1'b1, a[MW-1:0]};
                        r_mplier <= {1'b1, b[MW-1:0]};
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_exp    <= $signed(XW'(a[EW+MW-1:MW]))
                                  + $signed(XW'(b[EW+MW-1:MW])) - c_bias;
                        r_zero   <= (a[EW+MW-1:MW] == '0) || (b[EW+MW-1:MW] == '0);
                    end
                end
                S_MUL: begin
                    if (r_cnt != c_last_step) begin
                        if (r_mplier[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + CW'(1);
                    end
                end
                S_NORM: begin
                    if (r_zero || (w_exp_r <= c_exp_zero)) begin
                        out <= '0;
                        ovf <= 1'b0;
                        unf <= 1'b1;
                    end else if (w_exp_r >= c_exp_max) begin
                        out <= {{EW{1'b1}}, {MW{1'b0}}};
                        ovf <= 1'b1;
                        unf <= 1'b0;
                    end else begin
                        out <= {w_exp_r[EW-1:0], w_frac_r[MW-1:0]};
                        ovf <= 1'b0;
                        unf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fmul_mag_core.sv
`default_nettype none
// Testbench for fmul_mag_core: directed vectors, hand-computed results and a
// cycle-level reference model of latency, busy/done and result hold behaviour.
module tb_fmul_mag_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [30:0] a;
    logic [30:0] b;
    logic        busy;
    logic        done;
    logic [30:0] out;
    logic        ovf;
    logic        unf;

    int checks   = 0;
    int failures = 0;

    fmul_mag_core dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .ovf   (ovf),
        .unf   (unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Result packed as {ovf, unf, out}. Works on real values: exact integer
    // product, then nearest-even decided by comparing the discarded part to half.
    function automatic logic [32:0] model(input logic [30:0] xa, input logic [30:0] xb);
        logic [63:0] ma, mb, p, mant, rem, half;
        int ea, eb, e, sh;
        ea = int'(xa[30:23]);
        eb = int'(xb[30:23]);
        if (ea == 0 || eb == 0) return {1'b0, 1'b1, 31'd0};
        ma = {40'd0, 1'b1, xa[22:0]};
        mb = {40'd0, 1'b1, xb[22:0]};
        p  = ma * mb;
        e  = ea + eb - 127;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        mant = p >> sh;
        rem  = p & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
`ifdef ROUND_NEAREST_EN
        if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
        if (mant == (64'd1 << 24)) begin
            mant = mant >> 1;
            e    = e + 1;
        end
`else
        if (rem > half) mant = mant + 64'd0;
`endif
        if (e >= 255) return {1'b1, 1'b0, 31'h7F800000};
        if (e <= 0) return {1'b0, 1'b1, 31'd0};
        return {1'b0, 1'b0, 8'(e), mant[22:0]};
    endfunction

    // Reference timing: acceptance edge -> busy for 26 cycles -> done for one.
    bit          armed   = 1'b0;
    bit          pending = 1'b0;
    int          age     = 0;
    logic [32:0] m_res   = '0;
    logic [32:0] h_res   = '0;

    initial begin : scoreboard
        logic e_busy, e_done;
        logic [32:0] e_res;
        forever begin
            @(posedge clk);
            if (rst) begin
                armed   = 1'b1;
                pending = 1'b0;
                age     = 0;
                h_res   = '0;
            end else if (armed) begin
                if (pending && age == 27) begin
                    pending = 1'b0;
                    h_res   = m_res;
                end else if (pending) begin
                    age++;
                end else if (start) begin
                    pending = 1'b1;
                    age     = 1;
                    m_res   = model(a, b);
                end
            end
            @(negedge clk);
            if (armed) begin
                e_busy = pending && (age <= 26);
                e_done = pending && (age == 27);
                e_res  = e_done ? m_res : h_res;
                chk("busy", {31'd0, busy}, {31'd0, e_busy});
                chk("done", {31'd0, done}, {31'd0, e_done});
                chk("out",  {1'b0, out},   {1'b0, e_res[30:0]});
                chk("ovf",  {31'd0, ovf},  {31'd0, e_res[32]});
                chk("unf",  {31'd0, unf},  {31'd0, e_res[31]});
            end
        end
    end

    task automatic wait_done(output bit ok);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (done === 1'b1);
        if (!ok) chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic do_op(input logic [30:0] xa, input logic [30:0] xb, input bit use_hand,
                         input logic [30:0] h_out, input logic h_ovf, input logic h_unf);
        bit ok;
        @(posedge clk); #1;
        a = xa; b = xb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 31'($urandom);
        b = 31'($urandom);
        wait_done(ok);
        if (ok && use_hand) begin
            chk("hand_out", {1'b0, out}, {1'b0, h_out});
            chk("hand_ovf", {31'd0, ovf}, {31'd0, h_ovf});
            chk("hand_unf", {31'd0, unf}, {31'd0, h_unf});
        end
        @(posedge clk); #1;
    endtask

    initial begin : driver
        bit ok;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_out",  {1'b0, out},   32'd0);
        rst = 1'b0;

        do_op(31'h3F800000, 31'h3F800000, 1'b1, 31'h3F800000, 1'b0, 1'b0);
        do_op(31'h3FC00000, 31'h3FC00000, 1'b1, 31'h40100000, 1'b0, 1'b0);
`ifdef ROUND_NEAREST_EN
        do_op(31'h3F800001, 31'h3FC00000, 1'b1, 31'h3FC00002, 1'b0, 1'b0);
`else
        do_op(31'h3F800001, 31'h3FC00000, 1'b1, 31'h3FC00001, 1'b0, 1'b0);
`endif
        do_op(31'h7F000000, 31'h40000000, 1'b1, 31'h7F800000, 1'b1, 1'b0);
        do_op(31'h00800000, 31'h00800000, 1'b1, 31'h00000000, 1'b0, 1'b1);
        do_op(31'h7F000000, 31'h3F800000, 1'b1, 31'h7F000000, 1'b0, 1'b0);
        do_op(31'h00800000, 31'h3F800000, 1'b1, 31'h00800000, 1'b0, 1'b0);
        do_op(31'h00800000, 31'h3F000000, 1'b1, 31'h00000000, 1'b0, 1'b1);
        do_op(31'h00000000, 31'h3F800000, 1'b1, 31'h00000000, 1'b0, 1'b1);
        do_op(31'h40000000, 31'h40400000, 1'b1, 31'h40C00000, 1'b0, 1'b0);
        do_op(31'h3FFFFFFF, 31'h3FFFFFFF, 1'b1, 31'h407FFFFE, 1'b0, 1'b0);
        do_op(31'h3FFFFFFF, 31'h3F800001, 1'b0, '0, 1'b0, 1'b0);
        do_op(31'h3FAAAAAB, 31'h3FD55555, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            do_op({8'(64 + $urandom_range(0, 127)), 23'($urandom)},
                  {8'(64 + $urandom_range(0, 127)), 23'($urandom)}, 1'b0, '0, 1'b0, 1'b0);
        end

        // start held high for the whole operation with changing operands
        @(posedge clk); #1;
        a = 31'h40000000; b = 31'h40400000; start = 1'b1;
        @(posedge clk); #1;
        a = 31'($urandom); b = 31'($urandom);
        begin : held_start
            int n = 0;
            while (done !== 1'b1 && n < 40) begin
                @(posedge clk); #1;
                a = 31'($urandom); b = 31'($urandom);
                n++;
            end
        end
        start = 1'b0;
        chk("held_done", {31'd0, done}, 32'd1);
        chk("held_out", {1'b0, out}, {1'b0, 31'h40C00000});
        repeat (3) @(posedge clk);
        #1;

        // reset in the middle of an operation
        a = 31'h3FC00000; b = 31'h3FC00000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_out",  {1'b0, out},   32'd0);
        do_op(31'h40400000, 31'h40400000, 1'b1, 31'h41100000, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
